// File: rtl/write_phase.sv
// Write-back stage: merges retiring results into the architectural register file,
// tracks per-register outstanding writes and counts retired micro-instructions.
package write_phase_pkg;
    localparam int REG_N = 17;
    localparam int RAX   = 0;
    localparam int RCX   = 1;
    localparam int RDX   = 2;
    localparam int RBX   = 3;
    localparam int RSP   = 4;
    localparam int EFL   = 16;

    typedef logic [63:0] reg_t;

    typedef enum logic [1:0] {
        BMD_64 = 2'd0,
        BMD_08 = 2'd1,
        BMD_16 = 2'd2,
        BMD_32 = 2'd3
    } bmd_t;

    typedef enum logic [3:0] {
        MIOP_NOP = 4'd0,
        MIOP_ALU = 4'd1,
        MIOP_LD  = 4'd2,
        MIOP_ST  = 4'd3,
        MIOP_BR  = 4'd4
    } miop_t;

    typedef struct packed {
        miop_t op;
        bmd_t  bmd;
    } miinst_t;

    typedef struct packed {
        miinst_t miinst;
        reg_t    d;
    } ew_reg_t;
endpackage

module write_phase
    import write_phase_pkg::*;
#(
    parameter int          POST_DEC_LD = 4,
    parameter logic [63:0] STACK_INIT  = 64'h0000_0000_000f_fff0
) (
    input  logic        clk,
    input  logic        rst,
    input  ew_reg_t     ew_reg,
    input  logic        wb_en,
    input  logic [3:0]  wb_dst,
    input  logic        eflags_update,
    input  logic [63:0] eflags,
    input  logic        iss_en,
    input  logic [3:0]  iss_dst,
    output reg_t        gpr [REG_N],
    output logic [15:0] pending,
    output logic [63:0] retired,
    output logic        err_pend
);
    localparam int             CW      = $clog2(POST_DEC_LD + 1);
    localparam logic [CW-1:0]  CNT_MAX = CW'(POST_DEC_LD);

    logic [CW-1:0] cnt [16];
    logic [15:0]   inc;
    logic [15:0]   dec;
    logic [4:0]    wb_idx;
    reg_t          wb_val;

    assign wb_idx = {1'b0, wb_dst};

    always_comb begin
        wb_val = ew_reg.d;
        case (ew_reg.miinst.bmd)
            BMD_08:  wb_val = {gpr[wb_idx][63:8], ew_reg.d[7:0]};
            BMD_32:  wb_val = {32'h0, ew_reg.d[31:0]};
            default: wb_val = ew_reg.d;
        endcase
    end

    always_comb begin
        inc     = '0;
        dec     = '0;
        pending = '0;
        for (int unsigned r = 0; r < 16; r++) begin
            inc[r]     = iss_en && (iss_dst == 4'(r));
            dec[r]     = wb_en && (wb_dst == 4'(r));
            pending[r] = (cnt[r] != '0);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int unsigned i = 0; i < REG_N; i++) gpr[i] <= '0;
            gpr[RSP] <= STACK_INIT;
            gpr[EFL] <= 64'h2;
            for (int unsigned r = 0; r < 16; r++) cnt[r] <= '0;
            err_pend <= 1'b0;
            retired  <= '0;
        end else begin
            if (wb_en) gpr[wb_idx] <= wb_val;
            // Placed after the GPR write so the flag update wins if both ever hit EFL.
            if (eflags_update) gpr[EFL] <= eflags;

            for (int unsigned r = 0; r < 16; r++) begin
                if (inc[r] && !dec[r]) begin
                    if (cnt[r] == CNT_MAX) err_pend <= 1'b1;
                    else                   cnt[r] <= cnt[r] + 1'b1;
                end else if (dec[r] && !inc[r]) begin
                    if (cnt[r] == '0) err_pend <= 1'b1;
                    else              cnt[r] <= cnt[r] - 1'b1;
                end
            end

            if (ew_reg.miinst.op != MIOP_NOP) retired <= retired + 64'd1;
        end
    end
endmodule
